// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Initiator side of the word-based data-memory interface. Turns one MEM-stage
// load/store request into one or two word-aligned accesses with byte enables.
// Store data is shifted into byte lanes. Load data is reassembled from up to
// two words, then truncated and sign/zero-extended.
//
// Ports:
//   clock, reset                 system clock, synchronous active-low reset
//   req_valid/req_ready          request handshake: a request is taken on a
//                                cycle where both are 1. req_ready is 1 only
//                                in IDLE. The requester must hold req_* stable
//                                while req_valid=1 and req_ready=0.
//   req_write/size/unsigned      store flag, size (0 byte, 1 half, 2 word,
//                                3 illegal), load zero-extend flag
//   req_addr/req_wdata           byte address (any alignment), store data
//   resp_valid/rdata/error       one-cycle completion pulse, no backpressure
//   mem_*                        byte-enabled, word-addressed memory port
//   dbg_state                    current FSM state (IDLE=0 ACC0=1 ACC1=2 RESP=3)
//
// Every mem_* and resp_* output is decoded from registered state only, so
// there is no combinational path from req_* to the memory.
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_enable,
  output logic                  mem_write_enable,
  output logic [3:0]            mem_byte_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    write_q, write_d;
  logic                    unsigned_q, unsigned_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;

  logic [1:0]              off;
  logic [7:0]              mask;
  logic                    split;
  logic [2*DATA_WIDTH-1:0] store_word;
  logic [2*DATA_WIDTH-1:0] load_pair;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [ADDR_WIDTH-1:0]   word0_addr;
  logic [ADDR_WIDTH-1:0]   word1_addr;

  assign off        = addr_q[1:0];
  assign word0_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // The natural overflow of the addition wraps the last word back to address 0.
  assign word1_addr = word0_addr + ADDR_WIDTH'(4);
  assign dbg_state  = state_q;

  // Byte mask over two consecutive words. The low nibble selects bytes of
  // word0 and the high nibble selects bytes of word1.
  always_comb begin
    mask = 8'h00;
    case (size_q)
      2'd0:    mask = 8'h01 << off;
      2'd1:    mask = 8'h03 << off;
      default: mask = 8'h0f << off;
    endcase
  end
  assign split = |mask[7:4];

  assign store_word = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};
  assign load_pair  = {hi_q, lo_q} >> {off, 3'b000};

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'b0, load_pair[7:0]}
                                     : {{24{load_pair[7]}}, load_pair[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'b0, load_pair[15:0]}
                                     : {{16{load_pair[15]}}, load_pair[15:0]};
      default: load_ext = load_pair[31:0];
    endcase
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    write_d          = write_q;
    unsigned_d       = unsigned_q;
    error_d          = error_q;
    wdata_d          = wdata_q;
    lo_d             = lo_q;
    hi_d             = hi_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = '0;
    resp_error       = 1'b0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_byte_enable  = 4'b0000;
    mem_address      = '0;
    mem_write_data   = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          lo_d       = '0;
          // hi stays 0 for non-split loads, so the reassembly can use it unconditionally.
          hi_d       = '0;
          error_d    = (req_size == 2'd3);
          state_d    = (req_size == 2'd3) ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_enable       = 1'b1;
        mem_address      = word0_addr;
        mem_write_enable = write_q;
        if (write_q) begin
          mem_byte_enable = mask[3:0];
          mem_write_data  = store_word[DATA_WIDTH-1:0];
        end else begin
          lo_d = mem_read_data;
        end
        state_d = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_enable       = 1'b1;
        mem_address      = word1_addr;
        mem_write_enable = write_q;
        if (write_q) begin
          mem_byte_enable = mask[7:4];
          mem_write_data  = store_word[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          hi_d = mem_read_data;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = error_q;
        resp_rdata = (write_q || error_q) ? '0 : load_ext;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // While reset is held, every output is quiet even before the state
    // register clears. This also stops a pending memory write.
    if (!reset) begin
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_rdata       = '0;
      resp_error       = 1'b0;
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_byte_enable  = 4'b0000;
      mem_address      = '0;
      mem_write_data   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      error_q    <= 1'b0;
      wdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      error_q    <= error_d;
      wdata_q    <= wdata_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master. It includes a small byte-enabled
// memory with asynchronous read and synchronous write. Each scenario task
// drives requests, records the memory accesses and the response, and compares
// them inline against hand-computed values.
module tb_lsu_mem_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [3:0]  mem_byte_enable;
  logic [11:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  // Observations recorded by run_req.
  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        ready_seen;
  int          n_acc;
  logic [11:0] a_addr[2];
  logic [3:0]  a_be[2];
  logic        a_we[2];
  logic [31:0] a_wd[2];

  lsu_mem_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory ----------------
  logic [31:0] mem_arr[1024];

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
  end

  assign mem_read_data = (mem_enable && !mem_write_enable) ? mem_arr[mem_address[11:2]] : 32'h0;

  always @(posedge clock) begin
    if (mem_enable && mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem_arr[mem_address[11:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  // ---------------- driver ----------------
  // Issue one request, then watch up to 8 cycles for the memory accesses and
  // the response. got_lat counts cycles from the handshake edge and stays 0
  // when no response arrives.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [11:0] a, input logic [31:0] wd);
    @(negedge clock);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    ready_seen   = req_ready;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
    got_lat   = 0;
    got_rdata = 32'hx;
    got_err   = 1'bx;
    n_acc     = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_enable) begin
        if (n_acc < 2) begin
          a_addr[n_acc] = mem_address;
          a_be[n_acc]   = mem_byte_enable;
          a_we[n_acc]   = mem_write_enable;
          a_wd[n_acc]   = mem_write_data;
        end
        n_acc++;
      end
      if (resp_valid) begin
        got_lat   = k;
        got_rdata = resp_rdata;
        got_err   = resp_error;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    tests_run++;
    if (resp_valid !== 1'b0 || mem_enable !== 1'b0 || mem_byte_enable !== 4'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got valid=%b en=%b be=%b expected 0", resp_valid, mem_enable, mem_byte_enable);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_aligned_word();
    run_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    tests_run++;
    if (n_acc !== 1 || a_addr[0] !== 12'h010 || a_be[0] !== 4'b1111 || a_we[0] !== 1'b1 || a_wd[0] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL aligned_store_acc: got n=%0d addr=%h be=%b we=%b wd=%h expected n=1 addr=010 be=1111 we=1 wd=deadbeef", n_acc, a_addr[0], a_be[0], a_we[0], a_wd[0]);
    end
    tests_run++;
    if (got_lat !== 2 || got_rdata !== 32'h0 || got_err !== 1'b0) begin
      tests_failed++; $display("FAIL aligned_store_resp: got lat=%0d rdata=%h err=%b expected lat=2 rdata=0 err=0", got_lat, got_rdata, got_err);
    end
    run_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    tests_run++;
    if (n_acc !== 1 || a_be[0] !== 4'b0000 || a_we[0] !== 1'b0) begin
      tests_failed++; $display("FAIL aligned_load_acc: got n=%0d be=%b we=%b expected n=1 be=0000 we=0", n_acc, a_be[0], a_we[0]);
    end
    tests_run++;
    if (got_lat !== 2 || got_rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL aligned_load: got lat=%0d rdata=%h expected lat=2 rdata=deadbeef", got_lat, got_rdata);
    end
  endtask

  task automatic test_byte();
    run_req(1'b1, 2'd0, 1'b0, 12'h013, 32'h000000A5);
    tests_run++;
    if (a_addr[0] !== 12'h010 || a_be[0] !== 4'b1000 || a_wd[0] !== 32'hA5000000) begin
      tests_failed++; $display("FAIL byte_store: got addr=%h be=%b wd=%h expected addr=010 be=1000 wd=a5000000", a_addr[0], a_be[0], a_wd[0]);
    end
    run_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    tests_run++;
    if (got_rdata !== 32'hFFFFFFA5) begin tests_failed++; $display("FAIL byte_load_signed: got %h expected ffffffa5", got_rdata); end
    run_req(1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h000000A5) begin tests_failed++; $display("FAIL byte_load_unsigned: got %h expected 000000a5", got_rdata); end
  endtask

  task automatic test_split_word();
    run_req(1'b1, 2'd2, 1'b0, 12'h00E, 32'h11223344);
    tests_run++;
    if (n_acc !== 2 || a_addr[0] !== 12'h00C || a_be[0] !== 4'b1100 || a_wd[0] !== 32'h33440000) begin
      tests_failed++; $display("FAIL split_store_acc0: got n=%0d addr=%h be=%b wd=%h expected n=2 addr=00c be=1100 wd=33440000", n_acc, a_addr[0], a_be[0], a_wd[0]);
    end
    tests_run++;
    if (a_addr[1] !== 12'h010 || a_be[1] !== 4'b0011 || a_wd[1] !== 32'h00001122 || a_we[1] !== 1'b1) begin
      tests_failed++; $display("FAIL split_store_acc1: got addr=%h be=%b wd=%h we=%b expected addr=010 be=0011 wd=00001122 we=1", a_addr[1], a_be[1], a_wd[1], a_we[1]);
    end
    tests_run++;
    if (got_lat !== 3) begin tests_failed++; $display("FAIL split_store_lat: got %0d expected 3", got_lat); end
    run_req(1'b0, 2'd2, 1'b0, 12'h00E, 32'h0);
    tests_run++;
    if (got_lat !== 3 || got_rdata !== 32'h11223344) begin
      tests_failed++; $display("FAIL split_load: got lat=%0d rdata=%h expected lat=3 rdata=11223344", got_lat, got_rdata);
    end
  endtask

  task automatic test_wrap();
    run_req(1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000FF80);
    tests_run++;
    if (a_addr[0] !== 12'hFFC || a_be[0] !== 4'b1000 || a_wd[0] !== 32'h80000000) begin
      tests_failed++; $display("FAIL wrap_acc0: got addr=%h be=%b wd=%h expected addr=ffc be=1000 wd=80000000", a_addr[0], a_be[0], a_wd[0]);
    end
    tests_run++;
    if (n_acc !== 2 || a_addr[1] !== 12'h000 || a_be[1] !== 4'b0001 || a_wd[1] !== 32'h000000FF) begin
      tests_failed++; $display("FAIL wrap_acc1: got n=%0d addr=%h be=%b wd=%h expected n=2 addr=000 be=0001 wd=000000ff", n_acc, a_addr[1], a_be[1], a_wd[1]);
    end
    run_req(1'b0, 2'd1, 1'b0, 12'hFFF, 32'h0);
    tests_run++;
    if (got_lat !== 3 || got_rdata !== 32'hFFFFFF80) begin
      tests_failed++; $display("FAIL wrap_load_signed: got lat=%0d rdata=%h expected lat=3 rdata=ffffff80", got_lat, got_rdata);
    end
    run_req(1'b0, 2'd1, 1'b1, 12'hFFF, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h0000FF80) begin tests_failed++; $display("FAIL wrap_load_unsigned: got %h expected 0000ff80", got_rdata); end
  endtask

  task automatic test_illegal();
    run_req(1'b0, 2'd3, 1'b0, 12'h020, 32'h0);
    tests_run++;
    if (n_acc !== 0) begin tests_failed++; $display("FAIL illegal_no_access: got %0d accesses expected 0", n_acc); end
    tests_run++;
    if (got_lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL illegal_resp: got lat=%0d err=%b rdata=%h expected lat=1 err=1 rdata=0", got_lat, got_err, got_rdata);
    end
  endtask

  // Split store at 0x016: word 0x014 is written in ACC0, and reset is
  // asserted during ACC1 so word 0x018 must stay untouched.
  task automatic test_reset_mid();
    logic saw_resp;
    saw_resp = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h016; req_wdata = 32'hAABBCCDD;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);                   // ACC0
    tests_run++;
    if (mem_enable !== 1'b1 || mem_byte_enable !== 4'b1100) begin
      tests_failed++; $display("FAIL rstmid_acc0: got en=%b be=%b expected en=1 be=1100", mem_enable, mem_byte_enable);
    end
    @(posedge clock); #1;               // now in ACC1
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (mem_enable !== 1'b0 || mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_quiet: got en=%b we=%b valid=%b expected 0", mem_enable, mem_write_enable, resp_valid);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (resp_valid) saw_resp = 1'b1;
    end
    tests_run++;
    if (saw_resp !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_resp: got resp_valid=1 expected 0"); end
    run_req(1'b0, 2'd2, 1'b0, 12'h018, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstmid_word1: got %h expected 00000000", got_rdata); end
    run_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0);
    tests_run++;
    if (got_rdata !== 32'hCCDD0000) begin tests_failed++; $display("FAIL rstmid_word0: got %h expected ccdd0000", got_rdata); end
  endtask

  // Consecutive loads. Each one is issued in the cycle right after the
  // previous RESP, where req_ready must already be 1.
  // Memory at 0x00C = 33440000 and 0x010 = A5AD1122 by now.
  task automatic test_back_to_back();
    logic [11:0] addrs[5] = '{12'h010, 12'h012, 12'h012, 12'h011, 12'h00F};
    logic [1:0]  sizes[5] = '{2'd2,    2'd1,    2'd1,    2'd0,    2'd1};
    logic        unss[5]  = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
    logic [31:0] exp_r;
    exp_q.push_back(32'hA5AD1122);
    exp_q.push_back(32'h0000A5AD);
    exp_q.push_back(32'hFFFFA5AD);
    exp_q.push_back(32'h00000011);
    exp_q.push_back(32'h00002233);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0);
      exp_r = exp_q.pop_front();
      tests_run++;
      if (ready_seen !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready_seen); end
      tests_run++;
      if (got_rdata !== exp_r) begin tests_failed++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, got_rdata, exp_r); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 12'h0;
    req_wdata    = 32'h0;
    test_reset();
    test_aligned_word();
    test_byte();
    test_split_word();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
